// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: op codes, ALU function codes,
// FSM states and the queued command record.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_EQ    = 4'd2,
    OP_LT    = 4'd3,
    OP_LE    = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_PASSA = 4'd8,
    OP_SLL   = 4'd9,
    OP_SRL   = 4'd10,
    OP_SRA   = 4'd11
  } op_e;

  localparam logic [5:0] FN_NONE  = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b010000;
  localparam logic [5:0] FN_SUB   = 6'b010001;
  localparam logic [5:0] FN_EQ    = 6'b000010;
  localparam logic [5:0] FN_LT    = 6'b000100;
  localparam logic [5:0] FN_LE    = 6'b000110;
  localparam logic [5:0] FN_AND   = 6'b101000;
  localparam logic [5:0] FN_OR    = 6'b101110;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_PASSA = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b110000;
  localparam logic [5:0] FN_SRL   = 6'b110001;
  localparam logic [5:0] FN_SRA   = 6'b110011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        chain;
    logic [3:0]  tag;
  } cmd_t;

  function automatic logic [5:0] op_to_fn(input logic [3:0] op);
    case (op)
      OP_ADD:   return FN_ADD;
      OP_SUB:   return FN_SUB;
      OP_EQ:    return FN_EQ;
      OP_LT:    return FN_LT;
      OP_LE:    return FN_LE;
      OP_AND:   return FN_AND;
      OP_OR:    return FN_OR;
      OP_XOR:   return FN_XOR;
      OP_PASSA: return FN_PASSA;
      OP_SLL:   return FN_SLL;
      OP_SRL:   return FN_SRL;
      OP_SRA:   return FN_SRA;
      default:  return FN_NONE;
    endcase
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd11;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command queue; pointers carry one wrap bit so full and empty
// are distinguishable without a separate counter.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = do_push ? wptr_q + {{AW{1'b0}}, 1'b1} : wptr_q;
    rptr_d = do_pop  ? rptr_q + {{AW{1'b0}}, 1'b1} : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_seq.sv
// Command sequencer for an external combinational ALU: queues commands,
// drives one ALU operation per command and returns tagged responses.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_chain,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);
  cmd_t        wr_cmd, head;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  state_e      state_q;
  logic [31:0] acc_q;
  logic [31:0] alu_a_q, alu_b_q, drv_a_d;
  logic [5:0]  alu_fn_q, drv_fn_d;
  logic        legal_q;
  logic [3:0]  tag_q;
  logic        rsp_valid_q, rsp_zero_q, rsp_err_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  rsp_tag_q;

  assign wr_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain, tag: cmd_tag};
  assign cmd_ready = rst_n & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  // The head is consumed exactly when the FSM is about to enter DRIVE.
  assign fifo_pop  = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready));

  alu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    drv_a_d  = head.chain ? acc_q : head.a;
    drv_fn_d = op_to_fn(head.op);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fn_q    <= '0;
      legal_q     <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      // ALU operands are non-zero only in the cycle following a pop, i.e. DRIVE.
      if (fifo_pop) begin
        alu_a_q  <= drv_a_d;
        alu_b_q  <= head.b;
        alu_fn_q <= drv_fn_d;
        legal_q  <= op_legal(head.op);
        tag_q    <= head.tag;
      end else begin
        alu_a_q  <= '0;
        alu_b_q  <= '0;
        alu_fn_q <= '0;
      end
      case (state_q)
        ST_IDLE: if (fifo_pop) state_q <= ST_DRIVE;
        ST_DRIVE: begin
          rsp_valid_q <= 1'b1;
          rsp_tag_q   <= tag_q;
          state_q     <= ST_RESP;
          if (legal_q) begin
            rsp_data_q <= alu_out;
            rsp_zero_q <= (alu_out == 32'd0);
            rsp_err_q  <= 1'b0;
            acc_q      <= alu_out;
          end else begin
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b1;
            rsp_err_q  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= fifo_pop ? ST_DRIVE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fn    = alu_fn_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with an attached reference ALU, directed
// scenarios and randomized traffic under random response backpressure.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [3:0]  cmd_op, cmd_tag;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [5:0]  alu_fn;
  logic        rsp_valid, rsp_zero, rsp_err, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  always #5 clk = ~clk;

  alu_seq #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // Team ALU, keyed on the 6-bit function code.
  always_comb begin
    alu_out = 32'd0;
    case (alu_fn)
      6'b010000: alu_out = alu_a + alu_b;
      6'b010001: alu_out = alu_a - alu_b;
      6'b000010: alu_out = {31'd0, alu_a == alu_b};
      6'b000100: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'b000110: alu_out = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      6'b101000: alu_out = alu_a & alu_b;
      6'b101110: alu_out = alu_a | alu_b;
      6'b100110: alu_out = alu_a ^ alu_b;
      6'b101010: alu_out = alu_a;
      6'b110000: alu_out = alu_a << alu_b[4:0];
      6'b110001: alu_out = alu_a >> alu_b[4:0];
      6'b110011: alu_out = $signed(alu_a) >>> alu_b[4:0];
      default:   alu_out = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          bp_mode = 0;
  logic [31:0] acc_m = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return {31'd0, a == b};
      4'd3:    return {31'd0, $signed(a) < $signed(b)};
      4'd4:    return {31'd0, $signed(a) <= $signed(b)};
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return a;
      4'd9:    return a << b[4:0];
      4'd10:   return a >> b[4:0];
      4'd11:   return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Commands complete in acceptance order, so the model can run at accept time.
  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic ch, input logic [3:0] tag);
    logic [31:0] r;
    if (op > 4'd11) begin
      exp_q.push_back('{32'd0, tag, 1'b1, 1'b1});
    end else begin
      r = ref_result(op, ch ? acc_m : a, b);
      acc_m = r;
      exp_q.push_back('{r, tag, r == 32'd0, 1'b0});
    end
  endtask

  // Entered and left 2 ns after a rising edge; cmd_ready sampled 7 ns after.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ch, input logic [3:0] tag, input int max_cyc, output bit ok);
    ok = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_tag = tag;
    cmd_valid = 1'b1;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      #5;
      if (cmd_ready) begin
        ok = 1'b1;
        model_accept(op, a, b, ch, tag);
      end
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_must(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic ch, input logic [3:0] tag);
    bit ok;
    send(op, a, b, ch, tag, 200, ok);
    chk("cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int max_cyc);
    int i = 0;
    while ((exp_q.size() != 0 || busy) && i < max_cyc) begin
      @(posedge clk); #2;
      i++;
    end
    chk("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic wait_valid(input int max_cyc);
    int i = 0;
    while (!rsp_valid && i < max_cyc) begin
      @(posedge clk); #2;
      i++;
    end
    chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on each response handshake, checks hold stability.
  initial begin : monitor
    rsp_t        e;
    bit          hold_prev;
    logic [31:0] pd;
    logic [3:0]  pt;
    logic        pz, pe;
    hold_prev = 1'b0;
    pd = '0; pt = '0; pz = 1'b0; pe = 1'b0;
    forever begin
      @(posedge clk); #7;
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_data", rsp_data, pd);
          chk("hold_tag", 32'(rsp_tag), 32'(pt));
          chk("hold_flags", 32'({rsp_zero, rsp_err}), 32'({pz, pe}));
        end
        if (rsp_valid) begin
          chk("resp_alu_a_zero", alu_a, 32'd0);
          chk("resp_alu_b_zero", alu_b, 32'd0);
          chk("resp_alu_fn_zero", 32'(alu_fn), 32'd0);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got tag %0d data %h, expected no response", rsp_tag, rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end
        hold_prev = rsp_valid && !rsp_ready;
        pd = rsp_data; pt = rsp_tag; pz = rsp_zero; pe = rsp_err;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got %0d checks", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit          ok;
    int          cnt;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] corner [5];
    corner[0] = 32'd0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'd1; corner[4] = 32'h7FFF_FFFF;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_chain = 1'b0; cmd_tag = '0;

    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", 32'({rsp_tag, rsp_zero, rsp_err}), 32'd0);
    chk("rst_alu_fn", 32'(alu_fn), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD 5+7: latency and DRIVE-cycle operands.
    send_must(4'd0, 32'd5, 32'd7, 1'b0, 4'd3);
    chk("lat_edge_n", 32'(rsp_valid), 32'd0);
    @(posedge clk); #2;
    chk("lat_edge_n1", 32'(rsp_valid), 32'd0);
    chk("drive_fn_add", 32'(alu_fn), 32'h10);
    chk("drive_a", alu_a, 32'd5);
    chk("drive_b", alu_b, 32'd7);
    @(posedge clk); #2;
    chk("lat_edge_n2", 32'(rsp_valid), 32'd1);
    chk("add_data", rsp_data, 32'd12);
    wait_drain(20);

    // SUB to zero, then chained ADD.
    send_must(4'd1, 32'd9, 32'd9, 1'b0, 4'd1);
    send_must(4'd0, 32'd0, 32'd4, 1'b1, 4'd2);
    wait_drain(20);

    // Illegal op leaves fn at zero and the accumulator (4) untouched.
    send_must(4'd13, 32'd123, 32'd456, 1'b0, 4'd5);
    @(posedge clk); #2;
    chk("illegal_fn", 32'(alu_fn), 32'd0);
    send_must(4'd8, 32'hDEAD_BEEF, 32'd0, 1'b1, 4'd6);
    wait_drain(20);

    send_must(4'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd7);
    send_must(4'd10, 32'h8000_0000, 32'd4, 1'b0, 4'd8);
    wait_drain(20);

    // Park one response, then fill the queue behind it.
    bp_mode = 1;
    @(posedge clk); #2;
    send_must(4'd0, 32'd1, 32'd1, 1'b0, 4'd0);
    wait_valid(10);
    cnt = 0;
    for (int t = 1; t <= 5; t++) begin
      send(4'd6, 32'(t), 32'h100, 1'b0, 4'(t), 1, ok);
      cnt += int'(ok);
    end
    chk("fifo_accept_count", 32'(cnt), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    bp_mode = 0;
    wait_drain(50);

    // Randomized traffic with random backpressure.
    bp_mode = 2;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      send_must(op, a, b, 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
    end
    bp_mode = 0;
    wait_drain(200);

    // Reset while holding a response with two commands queued.
    bp_mode = 1;
    @(posedge clk); #2;
    send_must(4'd0, 32'd10, 32'd20, 1'b0, 4'd9);
    send_must(4'd0, 32'd11, 32'd21, 1'b0, 4'd10);
    send_must(4'd0, 32'd12, 32'd22, 1'b0, 4'd11);
    wait_valid(10);
    rst_n = 1'b0;
    exp_q.delete();
    acc_m = 32'd0;
    @(posedge clk); #2;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    bp_mode = 0;
    repeat (10) begin
      @(posedge clk); #2;
    end
    chk("after_rst_busy", 32'(busy), 32'd0);
    chk("after_rst_valid", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
